// File: rtl/read_logic_stream_out_if.sv
// AXI4-Stream byte interface used on the egress side of read_logic_stream_out.
// The master drives data, valid and last; the slave drives ready.
interface read_logic_stream_out_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/read_logic_stream_out.sv
// read_logic_stream_out: read-side sequencer and AXI4-Stream egress stage.
// Compares committed vs read line tribits, pulses rd_char_incr/rd_newline into the
// read counters, captures the 1-cycle-latency buffer RAM output and queues it in a
// 2-entry output FIFO that drives the master stream without bubbles inside a frame.
// Optional: define READ_LOGIC_FRAME_STATS_EN to add a saturating frames_sent_o counter.
module read_logic_stream_out #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUT_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              wr_ptr_tribit_i,
    input  logic [2:0]              rd_ptr_tribit_i,
    input  logic                    tlast_flag_i,
    input  logic [DATA_WIDTH-1:0]   rd_data_i,
    output logic                    rd_char_incr_o,
    output logic                    rd_newline_o,
    read_logic_stream_out_if.master m_axis
`ifdef READ_LOGIC_FRAME_STATS_EN
    ,
    output logic [15:0]             frames_sent_o
`endif
);

    // The FIFO pointers and occupancy arithmetic below assume exactly two entries.
    if (OUT_DEPTH != 2) begin : g_bad_depth
        $error("read_logic_stream_out supports OUT_DEPTH == 2 only");
    end

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } state_e;

    state_e state_q, state_d;

    logic                  inflight_q, inflight_d;
    logic                  cap_tlast_q, cap_tlast_d;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic                  fifo_wr_q, fifo_wr_d;
    logic                  fifo_rd_q, fifo_rd_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    logic                  empty;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [1:0]            occupancy;

    // Tribits carry a wrap bit, so plain equality distinguishes empty from full.
    assign empty = (rd_ptr_tribit_i == wr_ptr_tribit_i);

    assign pop  = m_axis.tvalid && m_axis.tready;
    assign push = inflight_q;

    // Slots still claimed after this cycle: a byte leaving now frees its slot, which is
    // what lets a 2-entry FIFO sustain one byte per cycle with a 1-cycle RAM latency.
    assign occupancy = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

    // Next-state and issue decision for the read sequencer.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (occupancy < 2'd2) begin
                    issue = 1'b1;
                    if (tlast_flag_i) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Mealy counter strobes; exactly one of them accompanies each issued byte.
    always_comb begin
        rd_char_incr_o = issue && !tlast_flag_i && !rst;
        rd_newline_o   = issue &&  tlast_flag_i && !rst;
    end

    // Track the byte whose RAM read is in flight and whether it closes its frame.
    always_comb begin
        inflight_d  = issue;
        cap_tlast_d = issue ? tlast_flag_i : cap_tlast_q;
    end

    // Sequencer state and in-flight tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            inflight_q  <= 1'b0;
            cap_tlast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            cap_tlast_q <= cap_tlast_d;
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        fifo_wr_d  = push ? ~fifo_wr_q : fifo_wr_q;
        fifo_rd_d  = pop  ? ~fifo_rd_q : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Output FIFO storage: the RAM word arrives the cycle after issue and is pushed then.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[fifo_wr_q] <= rd_data_i;
                fifo_last_q[fifo_wr_q] <= cap_tlast_q;
            end
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO head drives the stream; registered storage keeps it stable under backpressure.
    always_comb begin
        m_axis.tdata  = fifo_data_q[fifo_rd_q];
        m_axis.tlast  = fifo_last_q[fifo_rd_q];
        m_axis.tvalid = (fifo_cnt_q != 2'd0);
    end

`ifdef READ_LOGIC_FRAME_STATS_EN
    logic [15:0] frames_sent_q, frames_sent_d;

    // Count completed frames, holding at all-ones instead of wrapping.
    always_comb begin
        frames_sent_d = frames_sent_q;
        if (pop && m_axis.tlast && (frames_sent_q != 16'hFFFF)) begin
            frames_sent_d = frames_sent_q + 16'd1;
        end
    end

    // Frame statistics register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_sent_q <= 16'd0;
        end else begin
            frames_sent_q <= frames_sent_d;
        end
    end

    assign frames_sent_o = frames_sent_q;
`endif

endmodule

// File: tb/tb_read_logic_stream_out.sv
// Bench for read_logic_stream_out: models the upstream read counters and buffer RAM,
// keeps a queue of expected stream beats per committed frame, and checks every cycle.
module tb_read_logic_stream_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  wr_ptr = 3'd0;
    logic [2:0]  line_q = 3'd0;
    logic [11:0] char_q = 12'd0;
    logic        tlast_flag;
    logic [7:0]  rd_data = 8'd0;
    logic        rd_char_incr;
    logic        rd_newline;
    logic        bp_mode = 1'b0;
    logic [5:0]  bp_pat = 6'b101001;   // tready sequence 1,0,0,1,0,1 from bit 0 up

    int          frame_len [8];
    logic [7:0]  frame_base [8];
    logic [8:0]  exp_q [$];            // {tlast, tdata}
    logic [8:0]  log_q [$];            // accepted beats since last reset

    int cyc = 0;
    int issued = 0, popped = 0, incr_cnt = 0, nl_cnt = 0, gap = 0, last_nl_cyc = 0;
    bit nl_pend = 1'b0;
    int first_valid = -1, beats_last = 0, model_frames = 0;
    bit hold_prev = 1'b0, acc_nonlast_prev = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;

    int n_cmp = 0, n_fail = 0;

    read_logic_stream_out_if #(.DATA_WIDTH(8)) axis ();

`ifdef READ_LOGIC_FRAME_STATS_EN
    logic [15:0] frames_sent;
`endif

    read_logic_stream_out #(
        .DATA_WIDTH(8),
        .OUT_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_ptr_tribit_i(wr_ptr),
        .rd_ptr_tribit_i(line_q),
        .tlast_flag_i   (tlast_flag),
        .rd_data_i      (rd_data),
        .rd_char_incr_o (rd_char_incr),
        .rd_newline_o   (rd_newline),
        .m_axis         (axis)
`ifdef READ_LOGIC_FRAME_STATS_EN
        ,
        .frames_sent_o  (frames_sent)
`endif
    );

    always #5 clk = ~clk;

    assign tlast_flag  = (char_q == 12'(frame_len[line_q] - 1));
    assign axis.tready = bp_mode ? bp_pat[cyc % 6] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream model: read counters, registered RAM output, and issue bookkeeping.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            line_q   <= 3'd0;
            char_q   <= 12'd0;
            issued   <= 0;
            popped   <= 0;
            incr_cnt <= 0;
            nl_cnt   <= 0;
            gap      <= 0;
            nl_pend  <= 1'b0;
        end else begin
            rd_data <= frame_base[line_q] + char_q[7:0];
            if (rd_newline) begin
                line_q <= line_q + 3'd1;
                char_q <= 12'd0;
            end else if (rd_char_incr) begin
                char_q <= char_q + 12'd1;
            end
            if (rd_char_incr || rd_newline) begin
                issued <= issued + 1;
                if (nl_pend) begin
                    gap     <= cyc - last_nl_cyc;
                    nl_pend <= 1'b0;
                end
            end
            if (rd_char_incr) incr_cnt <= incr_cnt + 1;
            if (rd_newline) begin
                nl_cnt      <= nl_cnt + 1;
                last_nl_cyc <= cyc;
                nl_pend     <= 1'b1;
            end
            if (axis.tvalid && axis.tready) popped <= popped + 1;
        end
    end

    // Compare process: scoreboard, hold-under-backpressure, no-bubble and strobe rules.
    always @(negedge clk) begin
        if (rst) begin
            check("strobes_gated_in_reset", {31'd0, rd_char_incr || rd_newline}, 32'd0);
            log_q.delete();
            first_valid      = -1;
            beats_last       = 0;
            model_frames     = 0;
            hold_prev        = 1'b0;
            acc_nonlast_prev = 1'b0;
        end else begin
            check("strobes_exclusive", {31'd0, rd_char_incr && rd_newline}, 32'd0);
            check("occupancy_le_2", {31'd0, (issued - popped) > 2}, 32'd0);
`ifdef READ_LOGIC_FRAME_STATS_EN
            check("frames_sent", {16'd0, frames_sent}, model_frames);
`endif
            if (hold_prev) begin
                check("hold_stable", {22'd0, axis.tvalid, axis.tlast, axis.tdata},
                      {22'd0, 1'b1, prev_last, prev_data});
            end
            if (acc_nonlast_prev) begin
                check("no_bubble_in_frame", {31'd0, axis.tvalid}, 32'd1);
            end
            if (axis.tvalid && first_valid < 0) first_valid = cyc;
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {23'd0, axis.tlast, axis.tdata}, 32'h1FF);
                end else begin
                    check("beat", {23'd0, axis.tlast, axis.tdata}, {23'd0, exp_q.pop_front()});
                end
                log_q.push_back({axis.tlast, axis.tdata});
                if (axis.tlast) begin
                    beats_last++;
                    if (model_frames != 32'hFFFF) model_frames++;
                end
            end
            hold_prev        = axis.tvalid && !axis.tready;
            acc_nonlast_prev = axis.tvalid && axis.tready && !axis.tlast;
            prev_data        = axis.tdata;
            prev_last        = axis.tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        wr_ptr = 3'd0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic commit(input int len, input logic [7:0] base);
        frame_len[wr_ptr]  = len;
        frame_base[wr_ptr] = base;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), 8'(base + 8'(i))});
        end
        wr_ptr = wr_ptr + 3'd1;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (!(exp_q.size() == 0 && line_q == wr_ptr && !axis.tvalid) && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain_done", {31'd0, n < max_cyc}, 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        int c0;
        int n;
        int iss;

        for (int i = 0; i < 8; i++) begin
            frame_len[i]  = 0;
            frame_base[i] = 8'd0;
        end

        // Reset state.
        do_reset();
        check("reset_tvalid", {31'd0, axis.tvalid}, 32'd0);
        check("reset_tlast", {31'd0, axis.tlast}, 32'd0);
        check("reset_tdata", {24'd0, axis.tdata}, 32'd0);
`ifdef READ_LOGIC_FRAME_STATS_EN
        check("reset_frames_sent", {16'd0, frames_sent}, 32'd0);
`endif

        // Single 4-byte frame, tready held high.
        commit(4, 8'hA1);
        c0 = cyc;
        wait_drain(50);
        check("single_latency", first_valid - c0, 32'd3);
        check("single_count", log_q.size(), 32'd4);
        check("single_first", {23'd0, log_q[0]}, 32'h0A1);
        check("single_third", {23'd0, log_q[2]}, 32'h0A3);
        check("single_last", {23'd0, log_q[3]}, 32'h1A4);
        check("single_incr", incr_cnt, 32'd3);
        check("single_newline", nl_cnt, 32'd1);

        // Backpressure: 6-byte frame under a toggling tready.
        do_reset();
        bp_mode = 1'b1;
        commit(6, 8'h10);
        wait_drain(100);
        bp_mode = 1'b0;
        check("bp_count", log_q.size(), 32'd6);
        check("bp_first", {23'd0, log_q[0]}, 32'h010);
        check("bp_last", {23'd0, log_q[5]}, 32'h115);

        // Back-to-back frames of 3 and 1 bytes committed together.
        do_reset();
        commit(3, 8'h30);
        commit(1, 8'h40);
        wait_drain(60);
        check("b2b_count", log_q.size(), 32'd4);
        check("b2b_a_last", {23'd0, log_q[2]}, 32'h132);
        check("b2b_one_byte", {23'd0, log_q[3]}, 32'h140);
        check("b2b_idle_gap", gap, 32'd2);
        check("b2b_rd_ptr", {29'd0, line_q}, 32'd2);
        check("b2b_newlines", nl_cnt, 32'd2);

        // Wrap: nine 1-byte frames, committed in two batches so the tribit passes 7->0.
        do_reset();
        for (int i = 0; i < 5; i++) commit(1, 8'(8'h50 + 8'(i)));
        wait_drain(80);
        for (int i = 0; i < 4; i++) commit(1, 8'(8'h55 + 8'(i)));
        wait_drain(80);
        check("wrap_tlast_beats", beats_last, 32'd9);
        check("wrap_rd_ptr", {29'd0, line_q}, 32'd1);
        check("wrap_ninth", {23'd0, log_q[8]}, 32'h158);
        check("wrap_incr", incr_cnt, 32'd0);
        iss = issued;
        repeat (20) tick();
        check("wrap_no_spurious_issue", issued, iss);
        check("wrap_idle_tvalid", {31'd0, axis.tvalid}, 32'd0);

        // Maximum 2048-byte frame.
        do_reset();
        commit(2048, 8'h00);
        wait_drain(2200);
        check("max_count", log_q.size(), 32'd2048);
        check("max_incr", incr_cnt, 32'd2047);
        check("max_newline", nl_cnt, 32'd1);
        check("max_penultimate", {23'd0, log_q[2046]}, 32'h0FE);
        check("max_last", {23'd0, log_q[2047]}, 32'h1FF);
        check("max_beats_last", beats_last, 32'd1);
`ifdef READ_LOGIC_FRAME_STATS_EN
        check("max_frames_sent", {16'd0, frames_sent}, 32'd1);
`endif

        // Reset at byte 5 of a 10-byte frame that follows a complete 2-byte frame.
        do_reset();
        commit(2, 8'h60);
        commit(10, 8'h70);
        n = 0;
        while (log_q.size() < 7 && n < 60) begin
            tick();
            n++;
        end
        check("midreset_reach_byte5", {31'd0, n < 60}, 32'd1);
        rst    = 1'b1;
        wr_ptr = 3'd0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("midreset_tvalid", {31'd0, axis.tvalid}, 32'd0);
`ifdef READ_LOGIC_FRAME_STATS_EN
        check("midreset_frames_sent", {16'd0, frames_sent}, 32'd0);
`endif
        repeat (10) tick();
        check("midreset_no_issue", issued, 32'd0);
        check("midreset_tvalid_later", {31'd0, axis.tvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
